// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard scoreboard: forward selects and
// the fetch-tracking state encoding.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_M    = 2'd1,
        FWD_W    = 2'd2
    } hazard_forward_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // MDU busy counter width; covers latencies 1..15.
    localparam int MDU_CNT_W = 4;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one source operand. The D-stage variant refuses to
// forward from M when M holds a load, since that value is not ready yet.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REGIDX_W = 5,
    parameter bit IS_D     = 1'b0
) (
    input  logic [REGIDX_W-1:0] src,
    input  logic                wr_en_m,
    input  logic [REGIDX_W-1:0] wr_dst_m,
    input  logic                wr_from_mem_m,
    input  logic                wr_en_w,
    input  logic [REGIDX_W-1:0] wr_dst_w,
    output logic [1:0]          sel
);

    logic hit_m;
    logic hit_w;
    logic m_ok;

    // Register 0 is never a forwarding source, so a zero destination never hits.
    assign hit_m = wr_en_m && (wr_dst_m != '0) && (wr_dst_m == src);
    assign hit_w = wr_en_w && (wr_dst_w != '0) && (wr_dst_w == src);
    assign m_ok  = IS_D ? ~wr_from_mem_m : 1'b1;

    // M has priority over W because it holds the younger result.
    always_comb begin
        sel = FWD_NONE;
        if (hit_m && m_ok) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit for the 5-stage core: stall/flush generation,
// operand forwarding, MDU busy tracking, stale-fetch discard and a
// stall-cycle performance counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REGIDX_W = 5,
    parameter int MDU_LAT  = 4,
    parameter int BR_IN_D  = 1,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ireq_valid,
    input  logic                iresp_data_ok,
    input  logic                dreq_valid,
    input  logic                dresp_data_ok,
    input  logic                redirect_d,
    input  logic                is_branch_d,
    input  logic                uses_rs_d,
    input  logic                uses_rt_d,
    input  logic [REGIDX_W-1:0] rs_d,
    input  logic [REGIDX_W-1:0] rt_d,
    input  logic [REGIDX_W-1:0] rs_e,
    input  logic [REGIDX_W-1:0] rt_e,
    input  logic                wr_en_e,
    input  logic                wr_en_m,
    input  logic                wr_en_w,
    input  logic [REGIDX_W-1:0] wr_dst_e,
    input  logic [REGIDX_W-1:0] wr_dst_m,
    input  logic [REGIDX_W-1:0] wr_dst_w,
    input  logic                wr_from_mem_e,
    input  logic                wr_from_mem_m,
    input  logic                mdu_start_e,
    input  logic                mdu_use_d,
    output logic                stall_f,
    output logic                stall_d,
    output logic                stall_e,
    output logic                stall_m,
    output logic                flush_d,
    output logic                flush_e,
    output logic                flush_w,
    output logic [1:0]          forward_d_a,
    output logic [1:0]          forward_d_b,
    output logic [1:0]          forward_e_a,
    output logic [1:0]          forward_e_b,
    output logic [PERF_W-1:0]   stall_cycles
);

    function automatic logic match(input logic [REGIDX_W-1:0] x,
                                   input logic en,
                                   input logic [REGIDX_W-1:0] dst);
        return en && (dst != '0) && (dst == x);
    endfunction

    fetch_state_t         state_q;
    fetch_state_t         state_d;
    logic [MDU_CNT_W-1:0] mdu_cnt;

    logic rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;
    logic load_stall, br_stall, mdu_stall, fetch_stall, dresp_stall, front;
    logic redirect_q;

    assign rs_hit_e = uses_rs_d && match(rs_d, wr_en_e, wr_dst_e);
    assign rt_hit_e = uses_rt_d && match(rt_d, wr_en_e, wr_dst_e);
    assign rs_hit_m = uses_rs_d && match(rs_d, wr_en_m, wr_dst_m);
    assign rt_hit_m = uses_rt_d && match(rt_d, wr_en_m, wr_dst_m);

    assign load_stall  = wr_from_mem_e && (rs_hit_e || rt_hit_e);
    assign br_stall    = (BR_IN_D != 0) && is_branch_d &&
                         (rs_hit_e || rt_hit_e || (wr_from_mem_m && (rs_hit_m || rt_hit_m)));
    assign mdu_stall   = mdu_use_d && (mdu_cnt != '0);
    assign fetch_stall = (ireq_valid && !iresp_data_ok) || (state_q == DISCARD);
    assign dresp_stall = dreq_valid && !dresp_data_ok;
    assign front       = load_stall || br_stall || mdu_stall || fetch_stall;

    assign stall_f    = front || dresp_stall;
    assign stall_d    = stall_f;
    assign stall_e    = dresp_stall;
    assign stall_m    = dresp_stall;
    // E is held during a data wait, so no bubble may be written into it.
    assign flush_e    = front && !dresp_stall;
    assign flush_w    = dresp_stall;
    assign flush_d    = (state_q == DISCARD) && iresp_data_ok;
    assign redirect_q = redirect_d && !stall_d;

    // Fetch-tracking state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next fetch state; a response in the redirect cycle is left to the datapath.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ireq_valid && !iresp_data_ok) state_d = WAIT;
            WAIT:    if (iresp_data_ok) state_d = IDLE;
                     else if (redirect_q) state_d = DISCARD;
            DISCARD: if (iresp_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // MDU busy counter; keeps counting down while the pipeline is stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mdu_cnt <= '0;
        end else if (mdu_start_e && !stall_e) begin
            mdu_cnt <= MDU_CNT_W'(MDU_LAT);
        end else if (mdu_cnt != '0) begin
            mdu_cnt <= mdu_cnt - MDU_CNT_W'(1);
        end
    end

    // Saturating count of cycles in which D is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if (stall_d && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

    hazard_fwd_sel #(.REGIDX_W(REGIDX_W), .IS_D(1'b1)) u_fwd_d_a (
        .src(rs_d), .wr_en_m(wr_en_m), .wr_dst_m(wr_dst_m), .wr_from_mem_m(wr_from_mem_m),
        .wr_en_w(wr_en_w), .wr_dst_w(wr_dst_w), .sel(forward_d_a)
    );

    hazard_fwd_sel #(.REGIDX_W(REGIDX_W), .IS_D(1'b1)) u_fwd_d_b (
        .src(rt_d), .wr_en_m(wr_en_m), .wr_dst_m(wr_dst_m), .wr_from_mem_m(wr_from_mem_m),
        .wr_en_w(wr_en_w), .wr_dst_w(wr_dst_w), .sel(forward_d_b)
    );

    hazard_fwd_sel #(.REGIDX_W(REGIDX_W), .IS_D(1'b0)) u_fwd_e_a (
        .src(rs_e), .wr_en_m(wr_en_m), .wr_dst_m(wr_dst_m), .wr_from_mem_m(wr_from_mem_m),
        .wr_en_w(wr_en_w), .wr_dst_w(wr_dst_w), .sel(forward_e_a)
    );

    hazard_fwd_sel #(.REGIDX_W(REGIDX_W), .IS_D(1'b0)) u_fwd_e_b (
        .src(rt_e), .wr_en_m(wr_en_m), .wr_dst_m(wr_dst_m), .wr_from_mem_m(wr_from_mem_m),
        .wr_en_w(wr_en_w), .wr_dst_w(wr_dst_w), .sel(forward_e_b)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a table of single-cycle
// vectors plus hand-written multi-cycle sequences, checked via a queue.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int RW = 5;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok;
    logic          redirect_d, is_branch_d, uses_rs_d, uses_rt_d;
    logic [RW-1:0] rs_d, rt_d, rs_e, rt_e;
    logic          wr_en_e, wr_en_m, wr_en_w;
    logic [RW-1:0] wr_dst_e, wr_dst_m, wr_dst_w;
    logic          wr_from_mem_e, wr_from_mem_m, mdu_start_e, mdu_use_d;
    logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [1:0]    forward_d_a, forward_d_b, forward_e_a, forward_e_b;
    logic [PW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REGIDX_W(RW), .MDU_LAT(4), .BR_IN_D(1), .PERF_W(PW)) dut (
        .clk(clk), .resetn(resetn),
        .ireq_valid(ireq_valid), .iresp_data_ok(iresp_data_ok),
        .dreq_valid(dreq_valid), .dresp_data_ok(dresp_data_ok),
        .redirect_d(redirect_d), .is_branch_d(is_branch_d),
        .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .wr_en_e(wr_en_e), .wr_en_m(wr_en_m), .wr_en_w(wr_en_w),
        .wr_dst_e(wr_dst_e), .wr_dst_m(wr_dst_m), .wr_dst_w(wr_dst_w),
        .wr_from_mem_e(wr_from_mem_e), .wr_from_mem_m(wr_from_mem_m),
        .mdu_start_e(mdu_start_e), .mdu_use_d(mdu_use_d),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .forward_d_a(forward_d_a), .forward_d_b(forward_d_b),
        .forward_e_a(forward_e_a), .forward_e_b(forward_e_b),
        .stall_cycles(stall_cycles)
    );

    typedef struct packed {
        logic          ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok;
        logic          redirect_d, is_branch_d, uses_rs_d, uses_rt_d;
        logic [RW-1:0] rs_d, rt_d, rs_e, rt_e;
        logic          wr_en_e, wr_en_m, wr_en_w;
        logic [RW-1:0] wr_dst_e, wr_dst_m, wr_dst_w;
        logic          wr_from_mem_e, wr_from_mem_m, mdu_start_e, mdu_use_d;
    } in_t;

    typedef struct packed {
        logic       sf, sd, se, sm, fd, fe, fw;
        logic [1:0] da, db, ea, eb;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    vec_t  vec[15];
    out_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic out_t mk(input logic sf, sd, se, sm, fd, fe, fw,
                                input logic [1:0] da, db, ea, eb);
        out_t o;
        o = '{sf:sf, sd:sd, se:se, sm:sm, fd:fd, fe:fe, fw:fw, da:da, db:db, ea:ea, eb:eb};
        return o;
    endfunction

    task automatic apply(input in_t v);
        ireq_valid = v.ireq_valid;       iresp_data_ok = v.iresp_data_ok;
        dreq_valid = v.dreq_valid;       dresp_data_ok = v.dresp_data_ok;
        redirect_d = v.redirect_d;       is_branch_d   = v.is_branch_d;
        uses_rs_d  = v.uses_rs_d;        uses_rt_d     = v.uses_rt_d;
        rs_d = v.rs_d; rt_d = v.rt_d;    rs_e = v.rs_e; rt_e = v.rt_e;
        wr_en_e = v.wr_en_e; wr_en_m = v.wr_en_m; wr_en_w = v.wr_en_w;
        wr_dst_e = v.wr_dst_e; wr_dst_m = v.wr_dst_m; wr_dst_w = v.wr_dst_w;
        wr_from_mem_e = v.wr_from_mem_e; wr_from_mem_m = v.wr_from_mem_m;
        mdu_start_e   = v.mdu_start_e;   mdu_use_d     = v.mdu_use_d;
    endtask

    task automatic check_out();
        out_t  got, e;
        string nm;
        got = '{sf:stall_f, sd:stall_d, se:stall_e, sm:stall_m, fd:flush_d,
                fe:flush_e, fw:flush_w, da:forward_d_a, db:forward_d_b,
                ea:forward_e_a, eb:forward_e_b};
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b (sf sd se sm fd fe fw da db ea eb)", nm, got, e);
        end
    endtask

    task automatic check_val(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] e);
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, e);
        end
    endtask

    // One cycle: drive at the falling edge, queue the expectation, sample before the rise.
    task automatic step(input in_t v, input out_t e, input string nm);
        @(negedge clk);
        apply(v);
        exp_q.push_back(e);
        name_q.push_back(nm);
        #2;
        check_out();
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        apply('0);
        resetn = 1'b0;
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
        name_q.push_back(nm);
        #2;
        check_out();
        check_val({nm, "_stall_cycles"}, stall_cycles, '0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    localparam logic [1:0] N = 2'd0, M = 2'd1, W = 2'd2;

    initial begin
        in_t  t;
        out_t z, fr, dr;
        z  = mk(0,0,0,0,0,0,0,N,N,N,N);
        fr = mk(1,1,0,0,0,1,0,N,N,N,N);
        dr = mk(1,1,1,1,0,0,1,N,N,N,N);

        resetn = 1'b0;
        apply('0);
        #1;
        do_reset("reset");

        t = '0;                                                      vec[0]  = '{"idle", t, z};
        t = '0; t.wr_en_e=1; t.wr_dst_e=3; t.wr_from_mem_e=1; t.uses_rs_d=1; t.rs_d=3;
                                                                     vec[1]  = '{"load_use", t, fr};
        t.uses_rs_d=0; t.rt_d=3;                                     vec[2]  = '{"load_unused", t, z};
        t = '0; t.wr_en_e=1; t.wr_dst_e=3; t.uses_rs_d=1; t.rs_d=3;  vec[3]  = '{"alu_no_branch", t, z};
        t = '0; t.is_branch_d=1; t.uses_rs_d=1; t.rs_d=5; t.wr_en_e=1; t.wr_dst_e=5;
                                                                     vec[4]  = '{"br_e", t, fr};
        t = '0; t.is_branch_d=1; t.uses_rt_d=1; t.rt_d=6; t.wr_en_m=1; t.wr_dst_m=6; t.wr_from_mem_m=1;
                                                                     vec[5]  = '{"br_m_load", t, fr};
        t.wr_from_mem_m=0;                     vec[6]  = '{"br_m_alu", t, mk(0,0,0,0,0,0,0,N,M,N,N)};
        t = '0; t.wr_en_m=1; t.wr_dst_m=7; t.wr_en_w=1; t.wr_dst_w=8;
        t.rs_e=7; t.rt_e=8; t.rs_d=7; t.rt_d=8; vec[7] = '{"fwd_mw", t, mk(0,0,0,0,0,0,0,M,W,M,W)};
        t = '0; t.wr_en_m=1; t.wr_dst_m=7; t.wr_from_mem_m=1; t.wr_en_w=1; t.wr_dst_w=7;
        t.rs_d=7; t.rs_e=7;                     vec[8] = '{"fwd_d_load_m", t, mk(0,0,0,0,0,0,0,W,N,M,N)};
        t = '0; t.wr_en_m=1; t.wr_en_w=1; t.wr_en_e=1; t.wr_from_mem_e=1; t.uses_rs_d=1;
        t.is_branch_d=1;                                             vec[9]  = '{"zero_index", t, z};
        t = '0; t.dreq_valid=1;                                      vec[10] = '{"dresp_wait", t, dr};
        t.dresp_data_ok=1;                                           vec[11] = '{"dresp_ok", t, z};
        t = '0; t.wr_dst_w=8; t.wr_dst_m=8; t.rs_e=8; t.rt_e=8; t.rs_d=8;
                                                                     vec[12] = '{"wr_en_off", t, z};
        t = '0; t.mdu_use_d=1;                                       vec[13] = '{"mdu_idle", t, z};
        t = '0; t.wr_en_m=1; t.wr_dst_m=9; t.wr_en_w=1; t.wr_dst_w=9; t.rt_e=9; t.rt_d=9;
                                                vec[14] = '{"m_over_w", t, mk(0,0,0,0,0,0,0,N,M,N,M)};

        foreach (vec[k]) step(vec[k].i, vec[k].o, vec[k].name);

        // Load-use: one stall, then the consumer in E forwards from M.
        t = '0; t.wr_en_e=1; t.wr_dst_e=3; t.wr_from_mem_e=1; t.uses_rs_d=1; t.rs_d=3;
        step(t, fr, "lw_stall");
        t = '0; t.wr_en_m=1; t.wr_dst_m=3; t.wr_from_mem_m=1; t.rs_e=3;
        step(t, mk(0,0,0,0,0,0,0,N,N,M,N), "lw_fwd_e");

        // Branch in D after an ALU writer: one stall, then forward from M.
        t = '0; t.is_branch_d=1; t.uses_rs_d=1; t.rs_d=5; t.wr_en_e=1; t.wr_dst_e=5;
        step(t, fr, "beq_stall");
        t = '0; t.is_branch_d=1; t.uses_rs_d=1; t.rs_d=5; t.wr_en_m=1; t.wr_dst_m=5;
        step(t, mk(0,0,0,0,0,0,0,M,N,N,N), "beq_fwd_d");

        // MDU: mult starts in E, mflo waits four cycles.
        do_reset("reset_pre_mdu");
        t = '0; t.mdu_start_e=1; t.mdu_use_d=1;
        step(t, z, "mdu_start");
        t = '0; t.mdu_use_d=1;
        for (int c = 0; c < 4; c++) step(t, fr, $sformatf("mdu_busy_%0d", c));
        step(t, z, "mdu_release");
        check_val("mdu_stall_cycles", stall_cycles, 32'd4);

        // Redirect while a fetch is outstanding, stale response arrives later.
        t = '0; t.ireq_valid=1;            step(t, fr, "fetch_req");
        t = '0; t.redirect_d=1;            step(t, z,  "fetch_redirect");
        t = '0;                            step(t, fr, "discard_0");
                                           step(t, fr, "discard_1");
        t = '0; t.iresp_data_ok=1;         step(t, mk(1,1,0,0,1,1,0,N,N,N,N), "discard_drop");
        t = '0;                            step(t, z,  "discard_done");

        // Redirect and response in the same WAIT cycle: no discard.
        t = '0; t.ireq_valid=1;                     step(t, fr, "race_req");
        t = '0; t.redirect_d=1; t.iresp_data_ok=1;  step(t, z,  "race_both");
        t = '0;                                     step(t, z,  "race_idle");

        // Data wait on top of a load-use hazard: E held, no bubble into E.
        t = '0; t.dreq_valid=1; t.wr_en_e=1; t.wr_dst_e=3; t.wr_from_mem_e=1; t.uses_rs_d=1; t.rs_d=3;
        step(t, dr, "dwait_0");
        step(t, dr, "dwait_1");
        t.dresp_data_ok=1;
        step(t, fr, "dwait_done");

        // Reset while in DISCARD returns to IDLE; the later response is not dropped.
        t = '0; t.ireq_valid=1;      step(t, fr, "rst_req");
        t = '0; t.redirect_d=1;      step(t, z,  "rst_redirect");
        t = '0;                      step(t, fr, "rst_discard");
        do_reset("reset_in_discard");
        t = '0; t.iresp_data_ok=1;   step(t, z,  "rst_resp_kept");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the 5-stage pipeline hazard unit. It generates stall, flush and forward-select signals for F/D/E/M/W, and adds three things the previous generation lacked:
- A busy counter for a multi-cycle MDU.
- A fetch-tracking FSM that discards a stale instruction response after a redirect.
- A stall-cycle performance counter.
It sits beside the datapath in mycpu and drives the pipeline-register enables and clears.

Parameters:
REGIDX_W, 5, register index width; index 0 is hardwired zero and is never a hazard or forward source.
MDU_LAT, 4, cycles the MDU is busy after a start leaves E (1..15).
BR_IN_D, 1, 1 = branches and jr resolve in D, which needs operands in D.
PERF_W, 32, stall counter width.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ireq_valid  in  1  fetch request outstanding
iresp_data_ok  in  1  fetch response this cycle
dreq_valid  in  1  data request outstanding
dresp_data_ok  in  1  data response this cycle
redirect_d  in  1  D redirects PC (taken branch or jump)
is_branch_d  in  1  D instruction compares or uses registers for control flow
uses_rs_d, uses_rt_d  in  1 each  D reads rs / rt
rs_d, rt_d, rs_e, rt_e  in  REGIDX_W each  source indices
wr_en_e, wr_en_m, wr_en_w  in  1 each  stage writes the register file
wr_dst_e, wr_dst_m, wr_dst_w  in  REGIDX_W each  destination indices
wr_from_mem_e, wr_from_mem_m  in  1 each  writeback value comes from a load
mdu_start_e  in  1  MDU op in E
mdu_use_d  in  1  D is any MDU op or a HI/LO read
stall_f, stall_d, stall_e, stall_m  out  1 each  hold pipeline register
flush_d, flush_e, flush_w  out  1 each  insert bubble
forward_d_a, forward_d_b, forward_e_a, forward_e_b  out  2 each  FWD_NONE=0, FWD_M=1, FWD_W=2
stall_cycles  out  PERF_W  count of cycles with stall_d=1

Behaviour:
- Reset (async, resetn=0): fetch FSM to IDLE, mdu_cnt=0, stall_cycles=0. All outputs are combinational from state and inputs. With idle inputs during reset, every stall and flush is 0.
- Hazard match(x, s): wr_en_s & wr_dst_s!=0 & wr_dst_s==x.
- load_stall = wr_from_mem_e & ((uses_rs_d & match(rs_d,e)) | (uses_rt_d & match(rt_d,e))).
- br_stall (only when BR_IN_D=1 and is_branch_d):
  - a match in E on a used source (any writer), or
  - a match in M with wr_from_mem_m.
- mdu_cnt:
  - Loads MDU_LAT when mdu_start_e & ~stall_e.
  - Otherwise decrements when nonzero; it decrements during stalls too.
  - mdu_stall = mdu_use_d & (mdu_cnt!=0).
- Fetch FSM:
  - IDLE -> WAIT on ireq_valid & ~iresp_data_ok.
  - WAIT -> IDLE on iresp_data_ok.
  - WAIT -> DISCARD on redirect_q & ~iresp_data_ok.
  - DISCARD -> IDLE on iresp_data_ok.
  - redirect_q = redirect_d & ~stall_d.
- fetch_stall = (ireq_valid & ~iresp_data_ok) | (state==DISCARD).
- flush_d = 1 in the DISCARD cycle where iresp_data_ok=1, which drops the stale instruction.
- dresp_stall = dreq_valid & ~dresp_data_ok.
- front = load_stall | br_stall | mdu_stall | fetch_stall.
- stall_f = stall_d = front | dresp_stall. stall_e = stall_m = dresp_stall.
- flush_e = front & ~dresp_stall, so a bubble is never inserted into a held E. flush_w = dresp_stall.
- Forwarding:
  - E operands: M wins over W; FWD_M if match(x,m), else FWD_W if match(x,w), else FWD_NONE.
  - D operands: same rule, except FWD_M is excluded when wr_from_mem_m (that case is covered by br_stall).
  - Register index 0 always yields FWD_NONE.
- stall_cycles increments each cycle stall_d=1 and saturates at all-ones.
- Simultaneous events:
  - Redirect and data_ok in the same WAIT cycle: go to IDLE, no discard; the response belongs to the redirecting instruction's successor slot and is flushed by the datapath's normal redirect.
  - mdu_start_e while mdu_cnt!=0 cannot occur, because mdu_stall holds the op in D.
- Reset mid-operation (e.g. in DISCARD) returns to IDLE immediately; the pending response is not discarded.

Decomposition:
- Package hazard_pkg (extend control.svh): hazard_forward_t enum (FWD_NONE/FWD_M/FWD_W), fetch_state_t enum (IDLE/WAIT/DISCARD).
- One sub-module, hazard_fwd_sel, instantiated four times with a parameter for the D or E variant. It maps a source index plus M/W write info to a select.

Test Plan:
- lw $3 in E, D uses rs=3, no bus waits -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; next cycle forward_e_a=FWD_M.
- beq in D reading $5, add $5 in E (BR_IN_D=1) -> 1 stall cycle; then forward_d_a=FWD_M.
- mult starts in E (MDU_LAT=4), mflo follows in D -> stall_d=1 for 4 cycles, then released; stall_cycles increases by 4.
- Fetch outstanding (ireq_valid=1, data_ok=0), redirect_d=1 -> DISCARD; data_ok arrives 3 cycles later -> flush_d=1 that cycle, stall_f low the next.
- dreq_valid=1, data_ok low for 2 cycles while load_stall=1 -> stall_e=stall_m=flush_w=1 and flush_e=0 both cycles.
- Writer with wr_dst_m=0 and wr_en_m=1, reader rs_e=0 -> forward_e_a=FWD_NONE and no stall; assert resetn=0 in DISCARD -> state IDLE, stall_cycles=0 immediately.
